// File: rtl/mini_src_control_unit.sv
// ---------------------------------------------------------------------------
// mini_src_control_unit
//
// Hardwired Moore control unit for the Mini SRC DataPath. It steps through
// fetch (T0..T2), decode (T3) and execute (T4..T7), and drives the
// DataPath enable / out-select strobes plus alu_control. Memory accesses are
// stretched by a wait-state counter. Stop parks the machine in IDLE between
// instructions, and halt parks it in HALT until the next reset.
//
// Ports
//   clk          system clock, rising edge
//   clr          asynchronous active-low reset
//   IR[31:0]     instruction register, opcode = IR[31:27]
//   CON_FF       branch condition from the DataPath
//   Stop         pause request, honoured only between instructions
//   Run          1 while executing T0..T7
//   Pout, MARen, IncPC, Pen, Read, Write, MDRen, MDROut, IRen
//                fetch / memory strobes
//   Gra, Grb, Grc, Rin, Rout, BAout, ConIn
//                register-select strobes
//   Yen, Cout, ZLOen, ZHIen, ZLOout
//                ALU path strobes (ZLOen and ZHIen always move together)
//   alu_control  ALU operation select, 5'b00000 when idle
// ---------------------------------------------------------------------------
module mini_src_control_unit #(
    parameter int unsigned MEM_WAIT = 1,
    parameter logic [4:0]  ALU_ADD  = 5'b00001,
    parameter logic [4:0]  ALU_SUB  = 5'b00010,
    parameter logic [4:0]  ALU_AND  = 5'b00011,
    parameter logic [4:0]  ALU_OR   = 5'b00100
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        Run,
    output logic        Pout,
    output logic        MARen,
    output logic        IncPC,
    output logic        Pen,
    output logic        Read,
    output logic        Write,
    output logic        MDRen,
    output logic        MDROut,
    output logic        IRen,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        ConIn,
    output logic        Yen,
    output logic        Cout,
    output logic        ZLOen,
    output logic        ZHIen,
    output logic        ZLOout,
    output logic [4:0]  alu_control
);

    typedef enum logic [3:0] {
        S_RESET, S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI,
        OP_LD, OP_LDI, OP_ST, OP_BR, OP_NOP, OP_HALT
    } op_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

    // Unlisted opcodes fall through to nop so an unknown word never wedges the machine.
    function automatic op_t decode_op(input logic [4:0] opc);
        case (opc)
            5'b00011: return OP_ADD;
            5'b00100: return OP_SUB;
            5'b00101: return OP_AND;
            5'b00110: return OP_OR;
            5'b01100: return OP_ADDI;
            5'b01101: return OP_ANDI;
            5'b01110: return OP_ORI;
            5'b00000: return OP_LD;
            5'b00001: return OP_LDI;
            5'b00010: return OP_ST;
            5'b10011: return OP_BR;
            5'b11011: return OP_HALT;
            default:  return OP_NOP;
        endcase
    endfunction

    function automatic logic [4:0] alu_sel(input op_t op);
        case (op)
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR,  OP_ORI:  return ALU_OR;
            default:         return ALU_ADD;
        endcase
    endfunction

    state_t     state;
    state_t     state_nx;
    state_t     instr_end;
    op_t        op_q;
    op_t        op_cur;
    logic [3:0] wait_cnt;
    logic       wait_done;
    logic       zen;
    logic       ir_unused;

    // Only the opcode field steers the sequencer.
    assign ir_unused = ^IR[26:0];

    assign wait_done = (wait_cnt == 4'd0);

    // T3 decodes straight from IR; later states use the opcode captured at T3
    // so the sequence stays consistent even if IR moves during execute.
    always_comb begin
        op_cur = op_q;
        if (state == S_T3) begin
            op_cur = decode_op(IR[31:27]);
        end
    end

    // Stop is looked at only here, where one instruction hands over to the next.
    always_comb begin
        instr_end = Stop ? S_IDLE : S_T0;
    end

    // ---- state register, opcode capture and wait counter ----
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_RESET;
            op_q     <= OP_NOP;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_nx;
            if (state == S_T3) begin
                op_q <= op_cur;
            end
            // Reload on every state change; only wait states ever look at it.
            if (state_nx != state) begin
                wait_cnt <= WAIT_LOAD;
            end else if (!wait_done) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // ---- next-state decode ----
    always_comb begin
        state_nx = state;
        case (state)
            S_RESET: state_nx = S_IDLE;
            S_IDLE:  if (!Stop) state_nx = S_T0;
            S_T0:    state_nx = S_T1;
            S_T1:    if (wait_done) state_nx = S_T2;
            S_T2:    state_nx = S_T3;
            S_T3: begin
                case (op_cur)
                    OP_HALT: state_nx = S_HALT;
                    OP_NOP:  state_nx = instr_end;
                    default: state_nx = S_T4;
                endcase
            end
            S_T4:    state_nx = S_T5;
            S_T5: begin
                case (op_cur)
                    OP_LD, OP_ST, OP_BR: state_nx = S_T6;
                    default:             state_nx = instr_end;
                endcase
            end
            S_T6: begin
                case (op_cur)
                    OP_LD:   if (wait_done) state_nx = S_T7;
                    OP_ST:   state_nx = S_T7;
                    default: state_nx = instr_end;
                endcase
            end
            S_T7: begin
                case (op_cur)
                    OP_ST:   if (wait_done) state_nx = instr_end;
                    default: state_nx = instr_end;
                endcase
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_RESET;
        endcase
    end

    // ---- Moore output decode ----
    always_comb begin
        Run         = 1'b0;
        Pout        = 1'b0;
        MARen       = 1'b0;
        IncPC       = 1'b0;
        Pen         = 1'b0;
        Read        = 1'b0;
        Write       = 1'b0;
        MDRen       = 1'b0;
        MDROut      = 1'b0;
        IRen        = 1'b0;
        Gra         = 1'b0;
        Grb         = 1'b0;
        Grc         = 1'b0;
        Rin         = 1'b0;
        Rout        = 1'b0;
        BAout       = 1'b0;
        ConIn       = 1'b0;
        Yen         = 1'b0;
        Cout        = 1'b0;
        ZLOout      = 1'b0;
        zen         = 1'b0;
        alu_control = 5'b00000;

        case (state)
            S_T0: begin
                Pout  = 1'b1;
                MARen = 1'b1;
                IncPC = 1'b1;
                zen   = 1'b1;
            end
            S_T1: begin
                ZLOout = 1'b1;
                Pen    = 1'b1;
                Read   = 1'b1;
                MDRen  = 1'b1;
            end
            S_T2: begin
                MDROut = 1'b1;
                IRen   = 1'b1;
            end
            S_T3: begin
                case (op_cur)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yen  = 1'b1;
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        // Base register reads as zero when it is R0, hence BAout.
                        Grb   = 1'b1;
                        BAout = 1'b1;
                        Yen   = 1'b1;
                    end
                    OP_BR: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        ConIn = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_cur)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        Grc         = 1'b1;
                        Rout        = 1'b1;
                        zen         = 1'b1;
                        alu_control = alu_sel(op_cur);
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LD, OP_LDI, OP_ST: begin
                        Cout        = 1'b1;
                        zen         = 1'b1;
                        alu_control = alu_sel(op_cur);
                    end
                    OP_BR: begin
                        Pout = 1'b1;
                        Yen  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_cur)
                    OP_LD, OP_ST: begin
                        ZLOout = 1'b1;
                        MARen  = 1'b1;
                    end
                    OP_BR: begin
                        Cout        = 1'b1;
                        zen         = 1'b1;
                        alu_control = ALU_ADD;
                    end
                    default: begin
                        ZLOout = 1'b1;
                        Gra    = 1'b1;
                        Rin    = 1'b1;
                    end
                endcase
            end
            S_T6: begin
                case (op_cur)
                    OP_LD: begin
                        Read  = 1'b1;
                        MDRen = 1'b1;
                    end
                    OP_ST: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        MDRen = 1'b1;
                    end
                    OP_BR: begin
                        // Branch target only lands in PC when the condition held.
                        ZLOout = 1'b1;
                        Pen    = CON_FF;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_cur)
                    OP_LD: begin
                        MDROut = 1'b1;
                        Gra    = 1'b1;
                        Rin    = 1'b1;
                    end
                    OP_ST:   Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase

        Run   = (state == S_T0) || (state == S_T1) || (state == S_T2) || (state == S_T3) ||
                (state == S_T4) || (state == S_T5) || (state == S_T6) || (state == S_T7);
        ZLOen = zen;
        ZHIen = zen;
    end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mini_src_control_unit
//
// Scoreboard bench for mini_src_control_unit. Two instances share inputs:
// dut1 with MEM_WAIT=1 and dut2 with MEM_WAIT=2. Stimulus pushes the
// expected per-cycle output word into the queue of the targeted instance;
// a monitor per instance pops and compares on every falling edge (or on an
// explicit sample event for mid-cycle checks).
// ---------------------------------------------------------------------------
module tb_mini_src_control_unit;

    // Output word layout: {Run, Pout, MARen, IncPC, Pen, Read, Write, MDRen,
    // MDROut, IRen, Gra, Grb, Grc, Rin, Rout, BAout, ConIn, Yen, Cout,
    // ZLOen, ZHIen, ZLOout, alu_control[4:0]}
    localparam logic [26:0] RUN    = 27'd1 << 26;
    localparam logic [26:0] POUT   = 27'd1 << 25;
    localparam logic [26:0] MARN   = 27'd1 << 24;
    localparam logic [26:0] INCPC  = 27'd1 << 23;
    localparam logic [26:0] PEN    = 27'd1 << 22;
    localparam logic [26:0] READ   = 27'd1 << 21;
    localparam logic [26:0] WRITE  = 27'd1 << 20;
    localparam logic [26:0] MDREN  = 27'd1 << 19;
    localparam logic [26:0] MDROUT = 27'd1 << 18;
    localparam logic [26:0] IREN   = 27'd1 << 17;
    localparam logic [26:0] GRA    = 27'd1 << 16;
    localparam logic [26:0] GRB    = 27'd1 << 15;
    localparam logic [26:0] GRC    = 27'd1 << 14;
    localparam logic [26:0] RIN    = 27'd1 << 13;
    localparam logic [26:0] ROUT   = 27'd1 << 12;
    localparam logic [26:0] BAOUT  = 27'd1 << 11;
    localparam logic [26:0] CONIN  = 27'd1 << 10;
    localparam logic [26:0] YEN    = 27'd1 << 9;
    localparam logic [26:0] COUT   = 27'd1 << 8;
    localparam logic [26:0] ZEN    = (27'd1 << 7) | (27'd1 << 6);
    localparam logic [26:0] ZLOOUT = 27'd1 << 5;
    localparam logic [26:0] A_ADD  = 27'd1;
    localparam logic [26:0] A_SUB  = 27'd2;
    localparam logic [26:0] A_AND  = 27'd3;
    localparam logic [26:0] A_OR   = 27'd4;

    localparam logic [26:0] V_T0 = RUN | POUT | MARN | INCPC | ZEN;
    localparam logic [26:0] V_T1 = RUN | ZLOOUT | PEN | READ | MDREN;
    localparam logic [26:0] V_T2 = RUN | MDROUT | IREN;

    typedef struct {
        logic [26:0] v;
        string       tag;
    } exp_t;

    typedef struct {
        logic [31:0] ir;
        logic [26:0] t3;
        logic [26:0] t4;
        logic [26:0] t5;
        bit          ext;
        string       nm;
    } row_t;

    logic        clk;
    logic        clr;
    logic [31:0] IR;
    logic        CON_FF;
    logic        Stop;

    wire  [21:0] s1;
    wire  [21:0] s2;
    wire  [4:0]  a1;
    wire  [4:0]  a2;
    wire  [26:0] obs1 = {s1, a1};
    wire  [26:0] obs2 = {s2, a2};

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;
    row_t tbl[$];
    int   n_chk;
    int   n_fail;
    event mon_ev;

    mini_src_control_unit #(.MEM_WAIT(1)) dut1 (
        .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .Run(s1[21]), .Pout(s1[20]), .MARen(s1[19]), .IncPC(s1[18]), .Pen(s1[17]),
        .Read(s1[16]), .Write(s1[15]), .MDRen(s1[14]), .MDROut(s1[13]), .IRen(s1[12]),
        .Gra(s1[11]), .Grb(s1[10]), .Grc(s1[9]), .Rin(s1[8]), .Rout(s1[7]),
        .BAout(s1[6]), .ConIn(s1[5]), .Yen(s1[4]), .Cout(s1[3]), .ZLOen(s1[2]),
        .ZHIen(s1[1]), .ZLOout(s1[0]), .alu_control(a1)
    );

    mini_src_control_unit #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .Run(s2[21]), .Pout(s2[20]), .MARen(s2[19]), .IncPC(s2[18]), .Pen(s2[17]),
        .Read(s2[16]), .Write(s2[15]), .MDRen(s2[14]), .MDROut(s2[13]), .IRen(s2[12]),
        .Gra(s2[11]), .Grb(s2[10]), .Grc(s2[9]), .Rin(s2[8]), .Rout(s2[7]),
        .BAout(s2[6]), .ConIn(s2[5]), .Yen(s2[4]), .Cout(s2[3]), .ZLOen(s2[2]),
        .ZHIen(s2[1]), .ZLOout(s2[0]), .alu_control(a2)
    );

    always #5 clk = ~clk;

    // Monitors
    always begin
        @(negedge clk or mon_ev);
        if (q1.size() != 0) begin
            e1 = q1.pop_front();
            n_chk++;
            if (obs1 !== e1.v) begin
                n_fail++;
                $display("FAIL dut1 %s: got %h, expected %h", e1.tag, obs1, e1.v);
            end
        end
    end

    always begin
        @(negedge clk or mon_ev);
        if (q2.size() != 0) begin
            e2 = q2.pop_front();
            n_chk++;
            if (obs2 !== e2.v) begin
                n_fail++;
                $display("FAIL dut2 %s: got %h, expected %h", e2.tag, obs2, e2.v);
            end
        end
    end

    task automatic push(input int d, input logic [26:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        if (d == 1) q1.push_back(e);
        else        q2.push_back(e);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Wait for the monitor to consume everything queued; returns at negedge+1.
    task automatic drain(input int d, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (((d == 1) ? q1.size() : q2.size()) == 0) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL drain dut%0d: %0d vectors left, expected 0", d,
                 (d == 1) ? q1.size() : q2.size());
        q1.delete();
        q2.delete();
    endtask

    // Called at posedge+1. Holds reset for a few cycles, then releases it;
    // leaves RESET and IDLE expectations queued.
    task automatic go(input int d, input logic [31:0] ir);
        clr  = 1'b0;
        IR   = ir;
        Stop = 1'b0;
        push(d, 27'd0, "in_reset");
        push(d, 27'd0, "in_reset");
        drain(d, 6);
        sync();
        clr = 1'b1;
        push(d, 27'd0, "RESET");
        push(d, 27'd0, "IDLE");
    endtask

    task automatic fetch(input int d, input int w);
        push(d, V_T0, "T0");
        for (int i = 0; i <= w; i++) push(d, V_T1, "T1");
        push(d, V_T2, "T2");
    endtask

    task automatic add_row(input logic [31:0] ir, input logic [26:0] t3, input logic [26:0] t4,
                           input logic [26:0] t5, input bit ext, input string nm);
        row_t r;
        r.ir = ir; r.t3 = t3; r.t4 = t4; r.t5 = t5; r.ext = ext; r.nm = nm;
        tbl.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk    = 1'b0;
        clr    = 1'b0;
        IR     = 32'd0;
        CON_FF = 1'b0;
        Stop   = 1'b0;
        n_chk  = 0;
        n_fail = 0;

        // Power-on reset state on both instances
        sync();
        push(1, 27'd0, "por");
        push(2, 27'd0, "por");
        drain(1, 4);
        drain(2, 4);

        // st interrupted by reset while Write is high
        sync();
        go(1, 32'h1000_0000);
        fetch(1, 1);
        push(1, RUN | GRB | BAOUT | YEN, "st_T3");
        push(1, RUN | COUT | ZEN | A_ADD, "st_T4");
        push(1, RUN | ZLOOUT | MARN, "st_T5");
        push(1, RUN | GRA | ROUT | MDREN, "st_T6");
        drain(1, 16);
        @(posedge clk);
        #2;
        push(1, RUN | WRITE, "st_T7_write");
        -> mon_ev;
        #1;
        clr = 1'b0;
        #1;
        push(1, 27'd0, "st_abort_immediate");
        -> mon_ev;
        push(1, 27'd0, "st_abort_hold");
        push(1, 27'd0, "st_abort_hold");
        drain(1, 6);
        sync();
        clr = 1'b1;
        push(1, 27'd0, "after_abort_RESET");
        push(1, 27'd0, "after_abort_IDLE");
        push(1, V_T0, "after_abort_T0");
        drain(1, 8);

        // andi R2,R4,0x55: T0 to next T0 is 7 cycles with MEM_WAIT=1
        sync();
        go(1, 32'h6920_0055);
        fetch(1, 1);
        push(1, RUN | GRB | ROUT | YEN, "andi_T3");
        push(1, RUN | COUT | ZEN | A_AND, "andi_T4");
        push(1, RUN | ZLOOUT | GRA | RIN, "andi_T5");
        push(1, V_T0, "andi_next_T0");
        drain(1, 16);

        // ALU / immediate / ldi / nop table
        add_row(32'h1800_0000, RUN | GRB | ROUT | YEN, RUN | GRC | ROUT | ZEN | A_ADD, RUN | ZLOOUT | GRA | RIN, 1'b1, "add");
        add_row(32'h2000_0000, RUN | GRB | ROUT | YEN, RUN | GRC | ROUT | ZEN | A_SUB, RUN | ZLOOUT | GRA | RIN, 1'b1, "sub");
        add_row(32'h2800_0000, RUN | GRB | ROUT | YEN, RUN | GRC | ROUT | ZEN | A_AND, RUN | ZLOOUT | GRA | RIN, 1'b1, "and");
        add_row(32'h3000_0000, RUN | GRB | ROUT | YEN, RUN | GRC | ROUT | ZEN | A_OR,  RUN | ZLOOUT | GRA | RIN, 1'b1, "or");
        add_row(32'h6000_0000, RUN | GRB | ROUT | YEN, RUN | COUT | ZEN | A_ADD, RUN | ZLOOUT | GRA | RIN, 1'b1, "addi");
        add_row(32'h7000_0000, RUN | GRB | ROUT | YEN, RUN | COUT | ZEN | A_OR,  RUN | ZLOOUT | GRA | RIN, 1'b1, "ori");
        add_row(32'h0800_0000, RUN | GRB | BAOUT | YEN, RUN | COUT | ZEN | A_ADD, RUN | ZLOOUT | GRA | RIN, 1'b1, "ldi");
        add_row(32'hD000_0000, RUN, 27'd0, 27'd0, 1'b0, "nop");
        add_row(32'hF800_0000, RUN, 27'd0, 27'd0, 1'b0, "undef_as_nop");
        foreach (tbl[i]) begin
            sync();
            go(1, tbl[i].ir);
            fetch(1, 1);
            push(1, tbl[i].t3, {tbl[i].nm, "_T3"});
            if (tbl[i].ext) begin
                push(1, tbl[i].t4, {tbl[i].nm, "_T4"});
                push(1, tbl[i].t5, {tbl[i].nm, "_T5"});
            end
            push(1, V_T0, {tbl[i].nm, "_next_T0"});
            drain(1, 16);
        end

        // ld with MEM_WAIT=2: three-cycle Read in T1 and T6
        sync();
        go(2, 32'h0000_0000);
        fetch(2, 2);
        push(2, RUN | GRB | BAOUT | YEN, "ld_T3");
        push(2, RUN | COUT | ZEN | A_ADD, "ld_T4");
        push(2, RUN | ZLOOUT | MARN, "ld_T5");
        for (int i = 0; i < 3; i++) push(2, RUN | READ | MDREN, "ld_T6");
        push(2, RUN | MDROUT | GRA | RIN, "ld_T7");
        push(2, V_T0, "ld_next_T0");
        drain(2, 24);

        // st with MEM_WAIT=2: three-cycle Write
        sync();
        go(2, 32'h1000_0000);
        fetch(2, 2);
        push(2, RUN | GRB | BAOUT | YEN, "st2_T3");
        push(2, RUN | COUT | ZEN | A_ADD, "st2_T4");
        push(2, RUN | ZLOOUT | MARN, "st2_T5");
        push(2, RUN | GRA | ROUT | MDREN, "st2_T6");
        for (int i = 0; i < 3; i++) push(2, RUN | WRITE, "st2_T7");
        push(2, V_T0, "st2_next_T0");
        drain(2, 24);

        // br taken, then not taken
        for (int k = 0; k < 2; k++) begin
            sync();
            go(1, 32'h9800_0000);
            CON_FF = (k == 0);
            fetch(1, 1);
            push(1, RUN | GRA | ROUT | CONIN, "br_T3");
            push(1, RUN | POUT | YEN, "br_T4");
            push(1, RUN | COUT | ZEN | A_ADD, "br_T5");
            push(1, (k == 0) ? (RUN | ZLOOUT | PEN) : (RUN | ZLOOUT), (k == 0) ? "br_T6_taken" : "br_T6_not_taken");
            push(1, V_T0, "br_next_T0");
            drain(1, 16);
        end
        CON_FF = 1'b0;

        // Stop raised during T4 of add: instruction finishes, then IDLE
        sync();
        go(1, 32'h1800_0000);
        fetch(1, 1);
        push(1, RUN | GRB | ROUT | YEN, "stop_add_T3");
        push(1, RUN | GRC | ROUT | ZEN | A_ADD, "stop_add_T4");
        drain(1, 16);
        Stop = 1'b1;
        push(1, RUN | ZLOOUT | GRA | RIN, "stop_add_T5");
        push(1, 27'd0, "stop_IDLE");
        push(1, 27'd0, "stop_IDLE");
        drain(1, 8);
        Stop = 1'b0;
        push(1, V_T0, "resume_T0");
        drain(1, 4);

        // halt: HALT after T3, quiet for 20 cycles, left only by reset
        sync();
        go(1, 32'hD800_0000);
        fetch(1, 1);
        push(1, RUN, "halt_T3");
        for (int i = 0; i < 20; i++) push(1, 27'd0, "HALT");
        drain(1, 40);
        sync();
        go(1, 32'hD800_0000);
        push(1, V_T0, "halt_recover_T0");
        drain(1, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
